cons: RTL and testbench
=======================

// Module: cons
// PURPOSE
//   Consumer end of the val/data producer stream (no backpressure: every val=1 beat must be taken).
//   Buffers incoming beats in a FIFO and drains one entry every PROC_CYCLES cycles.
//   Emits each processed item, a running sum, burst statistics and a sticky overflow flag.
//   Sits directly on a producer's val/data outputs and feeds downstream logic or the bench monitor.
// PARAMETERS
//   DEPTH        8    FIFO entries; power of 2, >=2
//   PROC_CYCLES  2    cycles spent per item in PROC, >=1
//   SUM_W        16   width of running sum; wraps modulo 2^SUM_W
//   MAX_DATA     5    highest legal data value (used only with CONS_RANGE_CHK_EN)
// PORTS
//   clk        in   1      clock, rising edge
//   rst_b      in   1      asynchronous reset, active low
//   val        in   1      input beat valid, sampled every rising edge
//   data       in   8      input beat payload
//   out_val    out  1      one-cycle pulse: out_data is a processed item
//   out_data   out  8      processed item, held until next out_val
//   sum        out  SUM_W  running sum of all processed items
//   item_cnt   out  16     processed items, wraps
//   burst_cnt  out  16     val rising edges seen, wraps
//   last_len   out  8      length of most recent completed burst, saturates at 255
//   fifo_lvl   out  log2(DEPTH)+1  current FIFO occupancy
//   overflow   out  1      sticky: a beat was dropped because FIFO was full
//   range_err  out  1      sticky: out-of-range beat seen (0 when CONS_RANGE_CHK_EN undefined)
// BEHAVIOUR
//   Reset (rst_b=0, async): FSM=IDLE, FIFO empty, all outputs 0; abandons any item in flight.
//   Push: at an edge with val=1, data written at tail. Accepted if fifo_lvl<DEPTH, or if
//     fifo_lvl==DEPTH and a pop occurs at the same edge (level unchanged). Otherwise beat dropped,
//     overflow<=1 (stays 1 until reset). Pointers wrap modulo DEPTH.
//   FSM states IDLE, PROC; timer counts PROC_CYCLES-1..0:
//     IDLE: fifo_lvl>0 -> pop head into work reg, timer<=PROC_CYCLES-1, ->PROC; else stay.
//     PROC: timer!=0 -> timer--.
//           timer==0 -> out_val<=1, out_data<=work, sum<=sum+work, item_cnt++;
//           if fifo_lvl>0 pop next, reload timer, stay PROC; else ->IDLE.
//   Pop decision uses registered fifo_lvl; a beat pushed at edge t is poppable from edge t+1.
//   Latency: beat pushed into empty FIFO with FSM IDLE at edge t -> out_val high after edge
//     t+1+PROC_CYCLES. Steady-state throughput: one item per PROC_CYCLES cycles.
//   out_val is 0 in every cycle not listed above; out_data/sum otherwise hold.
//   Burst stats: val_d = val registered. val&~val_d -> burst_cnt++, run counter<=1;
//     val&val_d -> run++ (saturating 255); ~val&val_d -> last_len<=run. Burst stats count every
//     beat, including dropped and rejected beats.
//   Simultaneous burst end and new item: independent; both update the same edge.
// CONFIGURATION
//   CONS_RANGE_CHK_EN defined: beat with data>MAX_DATA is not pushed, range_err<=1 (sticky);
//     does not set overflow; still counted in burst stats.
//   CONS_RANGE_CHK_EN undefined: all beats pushed regardless of value; range_err tied 0.
// TESTING
//   1 Single beat data=3 at edge t, PROC_CYCLES=2 -> out_val only after edge t+3, out_data=3, sum=3, item_cnt=1.
//   2 Burst of 4 beats 1,2,3,4 -> out_data 1,2,3,4 spaced 2 cycles apart, sum=10,
//     burst_cnt=1, last_len=4, fifo_lvl returns to 0.
//   3 Continuous val=1 for 20 cycles, DEPTH=8 -> fifo_lvl reaches 8, overflow=1,
//     item_cnt at end == accepted beats, no duplicates/reorder.
//   4 Full FIFO plus pop at same edge as push -> beat accepted, fifo_lvl stays 8, overflow unchanged.
//   5 rst_b low mid-PROC with fifo_lvl=3 -> all outputs 0 immediately, no out_val after release until new beats.
//   6 With CONS_RANGE_CHK_EN, beats 2,7,4 -> out_data 2,4 only, sum=6, range_err=1, overflow=0;
//     without the macro: three items, sum=13, range_err=0.

Source files
------------

// File: rtl/cons.sv
// -----------------------------------------------------------------------------
// cons : consumer end of a val/data producer stream.
//
// Every val=1 beat is offered to an internal FIFO (no backpressure). A small
// IDLE/PROC engine pops one entry at a time, spends PROC_CYCLES cycles on it
// and then emits it on out_val/out_data. The block also keeps a running sum,
// a processed-item count, burst statistics and a sticky overflow flag.
//
// Optional feature macro: CONS_RANGE_CHK_EN
//   defined   : beats with data > MAX_DATA are rejected (not pushed) and set
//               the sticky range_err flag.
//   undefined : every beat is pushed and range_err is tied to 0.
//
// Ports
//   clk        in   1              clock, rising edge
//   rst_b      in   1              asynchronous reset, active low
//   val        in   1              input beat valid
//   data       in   8              input beat payload
//   out_val    out  1              one-cycle pulse, out_data is a new item
//   out_data   out  8              last processed item (held)
//   sum        out  SUM_W          running sum of processed items (wraps)
//   item_cnt   out  16             processed item count (wraps)
//   burst_cnt  out  16             number of val rising edges (wraps)
//   last_len   out  8              length of last completed burst (sat. 255)
//   fifo_lvl   out  log2(DEPTH)+1  FIFO occupancy
//   overflow   out  1              sticky: a beat was dropped on a full FIFO
//   range_err  out  1              sticky: an out-of-range beat was seen
// -----------------------------------------------------------------------------
module cons #(
  parameter int DEPTH       = 8,
  parameter int PROC_CYCLES = 2,
  parameter int SUM_W       = 16,
  parameter int MAX_DATA    = 5
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     val,
  input  logic [7:0]               data,
  output logic                     out_val,
  output logic [7:0]               out_data,
  output logic [SUM_W-1:0]         sum,
  output logic [15:0]              item_cnt,
  output logic [15:0]              burst_cnt,
  output logic [7:0]               last_len,
  output logic [$clog2(DEPTH):0]   fifo_lvl,
  output logic                     overflow,
  output logic                     range_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // A one-cycle PROC still needs a 1-bit timer to stay legal.
  localparam int TW = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [TW-1:0] T_LOAD   = TW'(PROC_CYCLES - 1);
  localparam logic [7:0]    MAX_D    = 8'(MAX_DATA);

  // Elaboration-time parameter sanity.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cons: DEPTH must be a power of 2 and >= 2");
  end
  if (PROC_CYCLES < 1) begin : g_bad_proc
    $error("cons: PROC_CYCLES must be >= 1");
  end
  if (MAX_DATA < 0 || MAX_DATA > 255) begin : g_bad_max
    $error("cons: MAX_DATA must fit in 8 bits");
  end

  typedef enum logic {IDLE, PROC} state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    lvl_q;

  state_t           state_q;
  logic [TW-1:0]    timer_q;
  logic [7:0]       work_q;
  logic             out_val_q;
  logic [7:0]       out_data_q;
  logic [SUM_W-1:0] sum_q;
  logic [15:0]      item_cnt_q;

  logic             val_d_q;
  logic [15:0]      burst_cnt_q;
  logic [7:0]       run_q;
  logic [7:0]       last_len_q;
  logic             overflow_q;

  // ---------------------------------------------------------------------------
  // Push / pop decisions (all based on the registered level)
  // ---------------------------------------------------------------------------
  logic          in_range;
  logic          push_req, push_ok, drop, pop;
  logic [LW-1:0] lvl_d;

  always_comb begin
`ifdef CONS_RANGE_CHK_EN
    in_range = (data <= MAX_D);
`else
    in_range = 1'b1;
`endif
    push_req = val & in_range;
    // IDLE pops as soon as anything is queued; PROC pops only as the current
    // item completes, so a pop and the item's out_val share one edge.
    pop      = (lvl_q != '0) && ((state_q == IDLE) || (timer_q == '0));
    // A full FIFO still takes a beat if the head leaves at the same edge.
    push_ok  = push_req && ((lvl_q != LVL_FULL) || pop);
    drop     = push_req && !push_ok;
    lvl_d    = lvl_q + LW'(push_ok) - LW'(pop);
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lvl_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      lvl_q <= lvl_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Processing FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      work_q     <= '0;
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      sum_q      <= '0;
      item_cnt_q <= '0;
    end else begin
      out_val_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            work_q  <= mem_q[rd_ptr_q];
            timer_q <= T_LOAD;
            state_q <= PROC;
          end
        end
        PROC: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            out_val_q  <= 1'b1;
            out_data_q <= work_q;
            sum_q      <= sum_q + SUM_W'(work_q);
            item_cnt_q <= item_cnt_q + 16'd1;
            if (pop) begin
              work_q  <= mem_q[rd_ptr_q];
              timer_q <= T_LOAD;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Burst statistics: every beat counts, accepted or not
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      val_d_q     <= 1'b0;
      burst_cnt_q <= '0;
      run_q       <= '0;
      last_len_q  <= '0;
    end else begin
      val_d_q <= val;
      if (val && !val_d_q) begin
        burst_cnt_q <= burst_cnt_q + 16'd1;
        run_q       <= 8'd1;
      end else if (val && val_d_q) begin
        if (run_q != 8'hFF) run_q <= run_q + 8'd1;
      end else if (!val && val_d_q) begin
        last_len_q <= run_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional range check
  // ---------------------------------------------------------------------------
`ifdef CONS_RANGE_CHK_EN
  logic range_err_q;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)               range_err_q <= 1'b0;
    else if (val && !in_range) range_err_q <= 1'b1;
  end
  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

  assign out_val   = out_val_q;
  assign out_data  = out_data_q;
  assign sum       = sum_q;
  assign item_cnt  = item_cnt_q;
  assign burst_cnt = burst_cnt_q;
  assign last_len  = last_len_q;
  assign fifo_lvl  = lvl_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cons.sv
// -----------------------------------------------------------------------------
// tb_cons : directed self-checking bench for cons (DEPTH=8, PROC_CYCLES=2).
// Inputs change 1ns after a rising edge; outputs are read 1ns after the edge
// or at the falling edge (monitor).
// -----------------------------------------------------------------------------
module tb_cons;

  logic        clk, rst_b, val;
  logic [7:0]  data;
  logic        out_val, overflow, range_err;
  logic [7:0]  out_data, last_len;
  logic [15:0] sum, item_cnt, burst_cnt;
  logic [3:0]  fifo_lvl;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int q_data[$];
  int q_cyc[$];

  cons #(.DEPTH(8), .PROC_CYCLES(2), .SUM_W(16), .MAX_DATA(5)) dut (
    .clk(clk), .rst_b(rst_b), .val(val), .data(data),
    .out_val(out_val), .out_data(out_data), .sum(sum), .item_cnt(item_cnt),
    .burst_cnt(burst_cnt), .last_len(last_len), .fifo_lvl(fifo_lvl),
    .overflow(overflow), .range_err(range_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: record every processed item with the edge count it followed.
  always @(negedge clk) begin
    if (out_val === 1'b1) begin
      q_data.push_back(int'(out_data));
      q_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    val   = 1'b0;
    data  = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    tick();
    q_data.delete();
    q_cyc.delete();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_b = 1'b0;
    val   = 1'b0;
    data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({out_val, out_data, sum, item_cnt, burst_cnt, last_len, fifo_lvl, overflow, range_err} !== '0) begin
      $display("FAIL reset_outputs: got ov=%0b od=%0d sum=%0d ic=%0d bc=%0d ll=%0d lvl=%0d of=%0b re=%0b, want all 0",
               out_val, out_data, sum, item_cnt, burst_cnt, last_len, fifo_lvl, overflow, range_err);
      n_fail++;
    end
    rst_b = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    int t0;
    do_reset();
    val = 1'b1; data = 8'd3;
    tick();
    t0 = cyc;
    val = 1'b0;
    repeat (6) tick();
    n_tests++;
    if (q_data.size() != 1) begin
      $display("FAIL single_count: got %0d items, want 1", q_data.size()); n_fail++;
    end
    n_tests++;
    if ((q_cyc.size() > 0 ? q_cyc[0] : -1) != t0 + 3) begin
      $display("FAIL single_latency: got edge %0d, want %0d", (q_cyc.size() > 0 ? q_cyc[0] : -1), t0 + 3); n_fail++;
    end
    n_tests++;
    if ((q_data.size() > 0 ? q_data[0] : -1) != 3) begin
      $display("FAIL single_data: got %0d, want 3", (q_data.size() > 0 ? q_data[0] : -1)); n_fail++;
    end
    n_tests++;
    if ({sum, item_cnt, out_data, out_val} !== {16'd3, 16'd1, 8'd3, 1'b0}) begin
      $display("FAIL single_state: got sum=%0d ic=%0d od=%0d ov=%0b, want 3 1 3 0", sum, item_cnt, out_data, out_val); n_fail++;
    end
    n_tests++;
    if ({burst_cnt, last_len} !== {16'd1, 8'd1}) begin
      $display("FAIL single_burst: got bc=%0d ll=%0d, want 1 1", burst_cnt, last_len); n_fail++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_burst4();
    int t0;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      val = 1'b1; data = 8'(i);
      tick();
      if (i == 1) t0 = cyc;
    end
    val = 1'b0;
    repeat (12) tick();
    n_tests++;
    if (q_data.size() != 4) begin
      $display("FAIL burst4_count: got %0d items, want 4", q_data.size()); n_fail++;
    end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_tests++;
      if (q_data[i] != i + 1 || q_cyc[i] != t0 + 3 + 2 * i) begin
        $display("FAIL burst4_item%0d: got data=%0d edge=%0d, want data=%0d edge=%0d",
                 i, q_data[i], q_cyc[i], i + 1, t0 + 3 + 2 * i);
        n_fail++;
      end
    end
    n_tests++;
    if ({sum, item_cnt, burst_cnt, last_len, fifo_lvl} !== {16'd10, 16'd4, 16'd1, 8'd4, 4'd0}) begin
      $display("FAIL burst4_totals: got sum=%0d ic=%0d bc=%0d ll=%0d lvl=%0d, want 10 4 1 4 0",
               sum, item_cnt, burst_cnt, last_len, fifo_lvl);
      n_fail++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // 20 back-to-back beats: FIFO fills at beat 14, beat 15 rides on a pop,
  // beats 16 and 18 are dropped, beats 17 and 19 are accepted.
  task automatic test_back_to_back();
    int exp[$];
    do_reset();
    for (int i = 0; i < 20; i++) begin
      val = 1'b1; data = 8'(i);
      tick();
      if (i == 14) begin
        n_tests++;
        if (fifo_lvl !== 4'd8) begin
          $display("FAIL b2b_full_lvl: got %0d, want 8", fifo_lvl); n_fail++;
        end
      end
      if (i == 15) begin
        n_tests++;
        if ({fifo_lvl, overflow} !== {4'd8, 1'b0}) begin
          $display("FAIL full_push_pop: got lvl=%0d of=%0b, want 8 0", fifo_lvl, overflow); n_fail++;
        end
      end
      if (i == 16) begin
        n_tests++;
        if ({fifo_lvl, overflow} !== {4'd8, 1'b1}) begin
          $display("FAIL b2b_drop: got lvl=%0d of=%0b, want 8 1", fifo_lvl, overflow); n_fail++;
        end
      end
    end
    val = 1'b0;
    repeat (50) tick();
    for (int i = 0; i < 16; i++) exp.push_back(i);
    exp.push_back(17);
    exp.push_back(19);
    n_tests++;
    if (q_data.size() != exp.size()) begin
      $display("FAIL b2b_count: got %0d items, want %0d", q_data.size(), exp.size()); n_fail++;
    end
    for (int i = 0; i < exp.size() && i < q_data.size(); i++) begin
      n_tests++;
      if (q_data[i] != exp[i]) begin
        $display("FAIL b2b_item%0d: got %0d, want %0d", i, q_data[i], exp[i]); n_fail++;
      end
    end
    n_tests++;
    if ({sum, item_cnt, overflow, last_len, burst_cnt, fifo_lvl} !== {16'd156, 16'd18, 1'b1, 8'd20, 16'd1, 4'd0}) begin
      $display("FAIL b2b_totals: got sum=%0d ic=%0d of=%0b ll=%0d bc=%0d lvl=%0d, want 156 18 1 20 1 0",
               sum, item_cnt, overflow, last_len, burst_cnt, fifo_lvl);
      n_fail++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_proc();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      val = 1'b1; data = 8'(i);
      tick();
    end
    val = 1'b0;
    n_tests++;
    if (fifo_lvl !== 4'd3) begin
      $display("FAIL midrst_pre_lvl: got %0d, want 3", fifo_lvl); n_fail++;
    end
    #2;
    rst_b = 1'b0;
    #1;
    n_tests++;
    if ({out_val, out_data, sum, item_cnt, burst_cnt, last_len, fifo_lvl, overflow, range_err} !== '0) begin
      $display("FAIL midrst_async: got ov=%0b od=%0d sum=%0d ic=%0d bc=%0d ll=%0d lvl=%0d of=%0b, want all 0",
               out_val, out_data, sum, item_cnt, burst_cnt, last_len, fifo_lvl, overflow);
      n_fail++;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    q_data.delete();
    q_cyc.delete();
    repeat (10) tick();
    n_tests++;
    if (q_data.size() != 0 || fifo_lvl !== 4'd0 || item_cnt !== 16'd0) begin
      $display("FAIL midrst_after: got %0d items lvl=%0d ic=%0d, want 0 0 0", q_data.size(), fifo_lvl, item_cnt);
      n_fail++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_range();
    int exp[$];
    int exp_sum;
    logic exp_re;
    do_reset();
    val = 1'b1; data = 8'd2; tick();
    data = 8'd7; tick();
    data = 8'd4; tick();
    val = 1'b0;
    repeat (12) tick();
`ifdef CONS_RANGE_CHK_EN
    exp = '{2, 4};
    exp_sum = 6;
    exp_re = 1'b1;
`else
    exp = '{2, 7, 4};
    exp_sum = 13;
    exp_re = 1'b0;
`endif
    n_tests++;
    if (q_data.size() != exp.size()) begin
      $display("FAIL range_count: got %0d items, want %0d", q_data.size(), exp.size()); n_fail++;
    end
    for (int i = 0; i < exp.size() && i < q_data.size(); i++) begin
      n_tests++;
      if (q_data[i] != exp[i]) begin
        $display("FAIL range_item%0d: got %0d, want %0d", i, q_data[i], exp[i]); n_fail++;
      end
    end
    n_tests++;
    if (int'(sum) != exp_sum || range_err !== exp_re || overflow !== 1'b0) begin
      $display("FAIL range_flags: got sum=%0d re=%0b of=%0b, want %0d %0b 0", sum, range_err, overflow, exp_sum, exp_re);
      n_fail++;
    end
    n_tests++;
    if ({burst_cnt, last_len} !== {16'd1, 8'd3}) begin
      $display("FAIL range_burst: got bc=%0d ll=%0d, want 1 3", burst_cnt, last_len); n_fail++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Bursts of 2 then 1 beat, then a 300-beat burst that saturates last_len.
  task automatic test_burst_stats();
    do_reset();
    data = 8'd1;
    val = 1'b1; tick();
    tick();
    val = 1'b0; tick();
    n_tests++;
    if ({burst_cnt, last_len} !== {16'd1, 8'd2}) begin
      $display("FAIL bstat_first: got bc=%0d ll=%0d, want 1 2", burst_cnt, last_len); n_fail++;
    end
    val = 1'b1; tick();
    val = 1'b0; tick();
    n_tests++;
    if ({burst_cnt, last_len} !== {16'd2, 8'd1}) begin
      $display("FAIL bstat_second: got bc=%0d ll=%0d, want 2 1", burst_cnt, last_len); n_fail++;
    end
    val = 1'b1;
    repeat (300) tick();
    val = 1'b0;
    tick();
    n_tests++;
    if ({burst_cnt, last_len, overflow} !== {16'd3, 8'd255, 1'b1}) begin
      $display("FAIL bstat_sat: got bc=%0d ll=%0d of=%0b, want 3 255 1", burst_cnt, last_len, overflow); n_fail++;
    end
  endtask

  initial begin
    rst_b = 1'b0;
    val   = 1'b0;
    data  = 8'd0;
    test_reset();
    test_single();
    test_burst4();
    test_back_to_back();
    test_reset_mid_proc();
    test_range();
    test_burst_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
